// File: rtl/arbiter_pkg.sv
// Shared definitions for the round-robin memory arbiter: FSM state encoding,
// default channel count and watchdog limit.
package arbiter_pkg;

  localparam int unsigned NCH_DEFAULT     = 3;
  localparam int unsigned TIMEOUT_DEFAULT = 255;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } arb_state_t;

  // Width of a channel index; never narrower than one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? int'($clog2(n)) : 1;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: the first requesting channel after
// i_last_grant (wrapping modulo NCH) wins; returns one-hot and index forms.
module rr_picker
  import arbiter_pkg::*;
#(
  parameter int unsigned NCH = NCH_DEFAULT,
  parameter int unsigned IW  = idx_w(NCH)
) (
  input  logic [NCH-1:0] i_req,
  input  logic [IW-1:0]  i_last_grant,
  output logic [NCH-1:0] o_grant,
  output logic [IW-1:0]  o_grant_idx
);

  logic          w_found;
  logic [IW-1:0] w_cand;

  always_comb begin
    o_grant     = '0;
    o_grant_idx = '0;
    w_found     = 1'b0;
    w_cand      = '0;
    // Walk last+1 .. last+NCH so the previous winner has lowest priority.
    for (int unsigned k = 1; k <= NCH; k++) begin
      w_cand = IW'((32'(i_last_grant) + k) % NCH);
      if (!w_found && i_req[w_cand]) begin
        w_found         = 1'b1;
        o_grant[w_cand] = 1'b1;
        o_grant_idx     = w_cand;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter_rr.sv
// Round-robin arbiter sharing one memory port among NCH requesters.
// Optional watchdog enabled by defining ARBITER_TIMEOUT_EN; WIDTH defaults to `MEMORY_WIDTH.
`ifndef MEMORY_WIDTH
`define MEMORY_WIDTH 32
`endif

module mem_arbiter_rr
  import arbiter_pkg::*;
#(
  parameter int unsigned NCH     = NCH_DEFAULT,
  parameter int unsigned WIDTH   = `MEMORY_WIDTH,
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NCH-1:0]       req_valid,
  input  logic [NCH-1:0]       req_rw,
  input  logic [NCH*32-1:0]    req_addr,
  input  logic [NCH*WIDTH-1:0] req_wdata,
  output logic [NCH-1:0]       req_ack,
  output logic [WIDTH-1:0]     req_rdata,
  output logic                 mem_enable,
  output logic                 mem_rw,
  input  logic                 mem_ack,
  output logic [31:0]          mem_addr,
  output logic [WIDTH-1:0]     mem_data_in,
  input  logic [WIDTH-1:0]     mem_data_out,
  output logic                 timeout_err
);

  localparam int unsigned IW = idx_w(NCH);

  if (NCH < 2 || NCH > 8) begin : g_nch_check
    $error("mem_arbiter_rr: NCH must be in 2..8");
  end
  if (TIMEOUT < 1) begin : g_timeout_check
    $error("mem_arbiter_rr: TIMEOUT must be at least 1");
  end

  arb_state_t       r_state;
  arb_state_t       w_state_nxt;
  logic [IW-1:0]    r_last_grant;
  logic [IW-1:0]    r_grant_idx;
  logic [NCH-1:0]   r_grant_oh;
  logic             r_mem_enable;
  logic             r_mem_rw;
  logic [31:0]      r_mem_addr;
  logic [WIDTH-1:0] r_mem_data_in;
  logic [NCH-1:0]   r_req_ack;
  logic [WIDTH-1:0] r_req_rdata;
  logic [NCH-1:0]   w_pick_oh;
  logic [IW-1:0]    w_pick_idx;
  logic             w_expired;
  logic [31:0]      w_ch_addr  [NCH];
  logic [WIDTH-1:0] w_ch_wdata [NCH];

  for (genvar i = 0; i < NCH; i++) begin : g_unpack
    assign w_ch_addr[i]  = req_addr[32*i +: 32];
    assign w_ch_wdata[i] = req_wdata[WIDTH*i +: WIDTH];
  end

  rr_picker #(
    .NCH (NCH),
    .IW  (IW)
  ) u_picker (
    .i_req        (req_valid),
    .i_last_grant (r_last_grant),
    .o_grant      (w_pick_oh),
    .o_grant_idx  (w_pick_idx)
  );

`ifdef ARBITER_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] r_busy_cnt;
  logic          r_timeout_err;

  // Expiry on the TIMEOUT-th BUSY cycle; a real mem_ack in that cycle wins.
  assign w_expired = (r_state == ST_BUSY) && !mem_ack && (r_busy_cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_busy_cnt    <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      r_busy_cnt    <= (r_state == ST_BUSY) ? r_busy_cnt + CW'(1) : '0;
      r_timeout_err <= w_expired;
    end
  end

  assign timeout_err = r_timeout_err;
`else
  assign w_expired   = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (|req_valid)             w_state_nxt = ST_BUSY;
      ST_BUSY: if (mem_ack || w_expired)   w_state_nxt = ST_DONE;
      ST_DONE:                             w_state_nxt = ST_IDLE;
      default:                             w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_last_grant  <= IW'(NCH - 1);
      r_grant_idx   <= '0;
      r_grant_oh    <= '0;
      r_mem_enable  <= 1'b0;
      r_mem_rw      <= 1'b0;
      r_mem_addr    <= '0;
      r_mem_data_in <= '0;
      r_req_ack     <= '0;
      r_req_rdata   <= '0;
    end else begin
      r_req_ack <= '0;
      case (r_state)
        ST_IDLE: begin
          if (|req_valid) begin
            r_grant_idx   <= w_pick_idx;
            r_grant_oh    <= w_pick_oh;
            r_mem_enable  <= 1'b1;
            r_mem_rw      <= req_rw[w_pick_idx];
            r_mem_addr    <= w_ch_addr[w_pick_idx];
            r_mem_data_in <= w_ch_wdata[w_pick_idx];
          end
        end
        ST_BUSY: begin
          if (mem_ack) begin
            r_mem_enable <= 1'b0;
            r_req_ack    <= r_grant_oh;
            if (!r_mem_rw) r_req_rdata <= mem_data_out;
          end else if (w_expired) begin
            r_mem_enable <= 1'b0;
            r_req_ack    <= r_grant_oh;
            r_req_rdata  <= '0;
          end
        end
        ST_DONE: r_last_grant <= r_grant_idx;
        default: ;
      endcase
    end
  end

  assign req_ack     = r_req_ack;
  assign req_rdata   = r_req_rdata;
  assign mem_enable  = r_mem_enable;
  assign mem_rw      = r_mem_rw;
  assign mem_addr    = r_mem_addr;
  assign mem_data_in = r_mem_data_in;

endmodule

// File: tb/tb_mem_arbiter_rr.sv
// Randomised + directed bench for mem_arbiter_rr with a transaction-level
// reference model and a scoreboard of memory read data.
module tb_mem_arbiter_rr;

  localparam int NCH     = 3;
  localparam int WIDTH   = 32;
  localparam int TIMEOUT = 8;
`ifdef ARBITER_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 reset;
  logic [NCH-1:0]       req_valid;
  logic [NCH-1:0]       req_rw;
  logic [NCH*32-1:0]    req_addr;
  logic [NCH*WIDTH-1:0] req_wdata;
  logic [NCH-1:0]       req_ack;
  logic [WIDTH-1:0]     req_rdata;
  logic                 mem_enable;
  logic                 mem_rw;
  logic                 mem_ack;
  logic [31:0]          mem_addr;
  logic [WIDTH-1:0]     mem_data_in;
  logic [WIDTH-1:0]     mem_data_out;
  logic                 timeout_err;

  always #5 clk = ~clk;

  mem_arbiter_rr #(
    .NCH     (NCH),
    .WIDTH   (WIDTH),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_rw       (req_rw),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .req_ack      (req_ack),
    .req_rdata    (req_rdata),
    .mem_enable   (mem_enable),
    .mem_rw       (mem_rw),
    .mem_ack      (mem_ack),
    .mem_addr     (mem_addr),
    .mem_data_in  (mem_data_in),
    .mem_data_out (mem_data_out),
    .timeout_err  (timeout_err)
  );

  int checks = 0;
  int errors = 0;

  logic [WIDTH-1:0] data_q[$];   // read data handed out with each real mem_ack
  int               ack_log[$];  // channel indices in the order req_ack pulsed

  int lat_mode = 0;   // 0: random 1..4, >0: fixed BUSY cycles, <0: never ack
  bit stray_en = 1'b0;
  int rcnt     = 0;
  int lat_cur  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  function automatic int rr_pick(input logic [NCH-1:0] v, input int last);
    for (int k = 1; k <= NCH; k++)
      if (v[(last + k) % NCH]) return (last + k) % NCH;
    return 0;
  endfunction

  task automatic raise(input int ch, input bit rw, input logic [31:0] a, input logic [WIDTH-1:0] d);
    req_valid[ch]              = 1'b1;
    req_rw[ch]                 = rw;
    req_addr[ch*32 +: 32]      = a;
    req_wdata[ch*WIDTH +: WIDTH] = d;
  endtask

  // One clock of stimulus: requesters drop acked requests / maybe raise new
  // ones, and the memory model answers after its chosen latency.
  task automatic step(input bit auto_req, input bit hold_all);
    logic [NCH-1:0] acked;
    @(posedge clk);
    #2;
    acked = req_ack;
    for (int ch = 0; ch < NCH; ch++) begin
      if (req_valid[ch] && acked[ch]) req_valid[ch] = 1'b0;
      else if (!req_valid[ch] && (hold_all || (auto_req && $urandom_range(0, 2) == 0)))
        raise(ch, 1'($urandom_range(0, 1)), $urandom, $urandom);
    end
    mem_data_out = $urandom;
    if (mem_ack) begin
      mem_ack = 1'b0;
      rcnt    = 0;
    end else if (mem_enable) begin
      if (rcnt == 0) lat_cur = (lat_mode == 0) ? int'($urandom_range(1, 4)) : lat_mode;
      rcnt++;
      if (lat_cur > 0 && rcnt >= lat_cur) begin
        mem_ack = 1'b1;
        data_q.push_back(mem_data_out);
      end
    end else begin
      rcnt = 0;
      if (stray_en && $urandom_range(0, 3) == 0) mem_ack = 1'b1;
    end
  endtask

  // Monitor: inputs seen at posedge+1 are what the DUT sampled at that edge.
  initial begin : monitor
    int               ph;     // 0 idle, 1 busy, 2 done
    int               g;
    int               last;
    int               bcnt;
    bit               to_m;
    logic [WIDTH-1:0] rdata_m;
    logic [WIDTH-1:0] d;
    logic [31:0]      p_addr;
    bit               p_rw;
    logic [WIDTH-1:0] p_wd;
    logic [NCH-1:0]   exp_ack;
    ph = 0; g = 0; last = NCH - 1; bcnt = 0; rdata_m = '0;
    p_addr = '0; p_rw = 1'b0; p_wd = '0;
    forever begin
      @(posedge clk);
      #1;
      to_m = 1'b0;
      if (reset) begin
        ph = 0; last = NCH - 1; rdata_m = '0;
        data_q.delete();
        chk("reset_mem_addr", mem_addr, 0);
        chk("reset_mem_rw", mem_rw, 0);
        chk("reset_mem_data_in", mem_data_in, 0);
      end else begin
        case (ph)
          0: if (req_valid != '0) begin
            g      = rr_pick(req_valid, last);
            p_addr = req_addr[g*32 +: 32];
            p_rw   = req_rw[g];
            p_wd   = req_wdata[g*WIDTH +: WIDTH];
            ph     = 1;
            bcnt   = 1;
          end
          1: if (mem_ack) begin
            ph = 2;
            if (data_q.size() == 0) fail_now("scoreboard_empty");
            else begin
              d = data_q.pop_front();
              if (!p_rw) rdata_m = d;
            end
          end else if (TO_EN && bcnt == TIMEOUT) begin
            ph = 2; to_m = 1'b1; rdata_m = '0;
          end else bcnt++;
          default: begin
            last = g;
            ph   = 0;
          end
        endcase
      end
      exp_ack = '0;
      if (ph == 2) exp_ack[g] = 1'b1;
      chk("mem_enable", mem_enable, (ph == 1));
      chk("req_ack", req_ack, exp_ack);
      chk("req_rdata", req_rdata, rdata_m);
      chk("timeout_err", timeout_err, to_m);
      if (ph == 1) begin
        chk("mem_addr", mem_addr, p_addr);
        chk("mem_rw", mem_rw, p_rw);
        chk("mem_data_in", mem_data_in, p_wd);
      end
      for (int c = 0; c < NCH; c++) if (req_ack[c] === 1'b1) ack_log.push_back(c);
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin : driver
    int seen;
    reset        = 1'b1;
    req_valid    = '0;
    req_rw       = '0;
    req_addr     = '0;
    req_wdata    = '0;
    mem_ack      = 1'b0;
    mem_data_out = '0;
    repeat (3) step(1'b0, 1'b0);
    reset = 1'b0;

    // Stray mem_ack while idle must be ignored.
    repeat (4) begin
      step(1'b0, 1'b0);
      mem_ack = 1'b1;
      step(1'b0, 1'b0);
    end

    // Single read on ch1 at 0x40, answered in the 3rd BUSY cycle.
    lat_mode = 3;
    raise(1, 1'b0, 32'h40, $urandom);
    repeat (8) step(1'b0, 1'b0);

    // Write on ch2; rdata must stay put.
    raise(2, 1'b1, 32'h1234, 32'hDEADBEEF);
    repeat (6) step(1'b0, 1'b0);

    // All channels held, immediate ack: order 0,1,2,0,1,2.
    ack_log.delete();
    lat_mode = 1;
    repeat (20) step(1'b0, 1'b1);
    repeat (10) step(1'b0, 1'b0);
    if (ack_log.size() < 6) fail_now("rr_order_count");
    else for (int i = 0; i < 6; i++) chk("rr_order", ack_log[i], i % 3);

    // Reset in the 2nd BUSY cycle abandons the transfer; ch0 wins afterwards.
    lat_mode = 6;
    raise(2, 1'b0, 32'h80, '0);
    seen = 0;
    for (int n = 0; n < 10 && seen < 2; n++) begin
      step(1'b0, 1'b0);
      if (mem_enable) seen++;
    end
    if (seen < 2) fail_now("reset_wait_busy");
    reset     = 1'b1;
    req_valid = '0;
    step(1'b0, 1'b0);
    reset = 1'b0;
    ack_log.delete();
    lat_mode = 2;
    for (int ch = 0; ch < NCH; ch++) raise(ch, 1'b0, 32'h100 + 32'(ch), '0);
    repeat (15) step(1'b0, 1'b0);
    if (ack_log.size() == 0) fail_now("post_reset_grant_missing");
    else chk("post_reset_first_grant", ack_log[0], 0);

    // Memory slow or silent: watchdog fires only when enabled.
    raise(1, 1'b0, 32'h200, '0);
`ifdef ARBITER_TIMEOUT_EN
    lat_mode = -1;
    repeat (14) step(1'b0, 1'b0);
`else
    lat_mode = 12;
    repeat (18) step(1'b0, 1'b0);
`endif

    // Random traffic with stray acks, then drain.
    lat_mode = 0;
    stray_en = 1'b1;
    repeat (1500) step(1'b1, 1'b0);
    stray_en = 1'b0;
    repeat (60) step(1'b0, 1'b0);
    chk("drain_valid", req_valid, 0);
    chk("scoreboard_left", data_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter_rr.md
MEM_ARBITER_RR -- requirements
Module: mem_arbiter_rr

Interface
REQ-001 SHALL have parameter NCH, default 3, the number of requester channels (range 2..8).
REQ-002 SHALL have parameter WIDTH, default `MEMORY_WIDTH, the memory line width in bits.
REQ-003 SHALL have parameter TIMEOUT, default 255, the watchdog limit in cycles (used only with ARBITER_TIMEOUT_EN).
REQ-004 SHALL have port clk, input, 1 bit, the single clock; all logic is rising-edge.
REQ-005 SHALL have port reset, input, 1 bit, synchronous active-high reset.
REQ-006 SHALL have port req_valid, input, NCH bits, per-channel request strobe, held until acked.
REQ-007 SHALL have port req_rw, input, NCH bits, per-channel direction: 1 is write, 0 is read.
REQ-008 SHALL have port req_addr, input, NCH*32 bits, packed channel addresses, channel i at [32*i +: 32].
REQ-009 SHALL have port req_wdata, input, NCH*WIDTH bits, packed channel write data.
REQ-010 SHALL have port req_ack, output, NCH bits, one-cycle completion pulse per channel.
REQ-011 SHALL have port req_rdata, output, WIDTH bits, the read data shared by all channels, valid when req_ack is high.
REQ-012 SHALL have port mem_enable, output, 1 bit, memory transaction strobe.
REQ-013 SHALL have port mem_rw, output, 1 bit, memory direction: 1 is write.
REQ-014 SHALL have port mem_ack, input, 1 bit, memory completion.
REQ-015 SHALL have port mem_addr, output, 32 bits, memory address.
REQ-016 SHALL have port mem_data_in, output, WIDTH bits, data to memory.
REQ-017 SHALL have port mem_data_out, input, WIDTH bits, data from memory.
REQ-018 SHALL have port timeout_err, output, 1 bit, one-cycle watchdog-expiry pulse.

Function
REQ-019 SHALL implement the FSM states IDLE, BUSY and DONE.
REQ-020 IDLE with any req_valid bit set SHALL grant exactly one channel g by round-robin, starting the search at last_grant+1 mod NCH, and go to BUSY on the next edge.
REQ-021 On the IDLE->BUSY transition the block SHALL register mem_addr, mem_rw and mem_data_in from channel g and assert mem_enable, so mem_enable is high in the first BUSY cycle (one-cycle grant latency).
REQ-022 BUSY SHALL hold mem_enable and all mem_* outputs stable until mem_ack=1.
REQ-023 On mem_ack=1 in BUSY the block SHALL capture mem_data_out into req_rdata, drop mem_enable and go to DONE.
REQ-024 DONE SHALL pulse req_ack[g] for exactly one cycle, set last_grant=g and return to IDLE; req_rdata SHALL hold until the next read capture.
REQ-025 A requester SHALL deassert req_valid in the cycle after req_ack; the DONE->IDLE bubble guarantees that no re-grant is taken from a stale valid.
REQ-026 Requests arriving in BUSY or DONE SHALL wait, with no loss and no reordering within a channel.
REQ-027 A single active requester SHALL be granted back-to-back; round-robin fairness applies only when two or more requesters are pending.
REQ-028 mem_ack outside BUSY SHALL be ignored.
REQ-029 Write transactions SHALL not modify req_rdata.

Reset
REQ-030 Reset SHALL set state=IDLE, mem_enable=0, mem_rw=0, mem_addr=0, mem_data_in=0, req_ack=0, req_rdata=0, timeout_err=0 and last_grant=NCH-1, so that channel 0 wins first.
REQ-031 Reset asserted in BUSY or DONE SHALL abandon the transaction: no req_ack is issued and mem_enable is low on the next cycle.

Configuration
REQ-032 Macro ARBITER_TIMEOUT_EN, when defined, SHALL add a BUSY cycle counter.
REQ-033 With ARBITER_TIMEOUT_EN defined, reaching TIMEOUT cycles without mem_ack SHALL pulse timeout_err, pulse req_ack[g] with req_rdata=0, and go through DONE to IDLE.
REQ-034 With ARBITER_TIMEOUT_EN undefined, the counter SHALL be absent, timeout_err SHALL be tied 0, and BUSY SHALL wait indefinitely.

Structure
REQ-035 Shared package arbiter_pkg SHALL hold the state encoding (IDLE/BUSY/DONE) and the default values of NCH and TIMEOUT.
REQ-036 The round-robin selection SHALL be a sub-module rr_picker (NCH-bit request vector and last_grant in; one-hot grant and index out), purely combinational.
REQ-037 The timeout counter width SHALL be $clog2(TIMEOUT+1).

Verification
REQ-038 Scenario 1: a single read on ch1 at addr 0x40 with mem_ack 3 cycles after mem_enable SHALL produce mem_enable high for 3 cycles, mem_addr=0x40, mem_rw=0, and req_ack[1] pulsing 1 cycle later with req_rdata equal to mem_data_out.
REQ-039 Scenario 2: req_valid=3'b111 held with immediate mem_ack SHALL produce the grant order 0,1,2,0,...
REQ-040 Scenario 3: a write on ch2 with data 0xDEADBEEF SHALL drive mem_rw=1 and mem_data_in=0xDEADBEEF, leaving req_rdata unchanged.
REQ-041 Scenario 4: reset asserted in the 2nd BUSY cycle SHALL produce no req_ack, mem_enable=0 on the next edge, and a first grant of ch0 afterwards.
REQ-042 Scenario 5: with ARBITER_TIMEOUT_EN defined, TIMEOUT=8 and mem_ack never asserted, timeout_err and req_ack[g] SHALL pulse after 8 BUSY cycles with req_rdata=0; with the macro undefined, timeout_err SHALL stay 0.
REQ-043 Scenario 6: a stray mem_ack in IDLE SHALL cause no state change and no req_ack.
